// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder and its RAM bank.
package mem_pkg;

   // Responder FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   // Bytes per word at the default 32-bit width
   localparam int WORD_BYTES = 32 / 8;

   // Byte-address bit where the word index starts
   localparam int ADDR_LSB = 2;

endpackage

// File: rtl/sp_ram_bank.sv
// Single-port synchronous RAM, DEPTH x N, with per-byte write enables.
// Contents are never reset.
module sp_ram_bank #(
   parameter int N     = 32,
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           en,
   input  logic [N/8-1:0] be,
   input  logic [AW-1:0]  addr,
   input  logic [N-1:0]   wdata,
   output logic [N-1:0]   rdata
);

   logic [N-1:0] mem [DEPTH];

   // One access per cycle: byte-masked write and registered read of the old word
   always_ff @(posedge clk) begin
      if (en) begin
         for (int unsigned k = 0; k < N / 8; k++) begin
            if (be[k]) begin
               mem[addr][k*8 +: 8] <= wdata[k*8 +: 8];
            end
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: valid/ready request and response channels in front of
// a single-port RAM, one outstanding word access, fixed access latency.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int N       = 32,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           i_req_valid,
   output logic           o_req_ready,
   input  logic           i_req_we,
   input  logic [N-1:0]   i_req_addr,
   input  logic [N-1:0]   i_req_wdata,
   input  logic [N/8-1:0] i_req_be,
   output logic           o_resp_valid,
   input  logic           i_resp_ready,
   output logic [N-1:0]   o_resp_rdata,
   output logic           o_resp_err
);

   localparam int AW = $clog2(DEPTH);

   state_t         state;
   logic [3:0]     cnt;
   logic           lat_we;
   logic [N-1:0]   lat_addr;
   logic [N-1:0]   lat_wdata;
   logic [N/8-1:0] lat_be;
   logic           ready_q;
   logic           valid_q;
   logic           err_q;
   logic           rd_ok;

   logic [N-1:0]   word_idx;
   logic           addr_err;
   logic           ram_en;
   logic [N/8-1:0] ram_be;
   logic [N-1:0]   ram_rdata;

   assign word_idx = lat_addr >> ADDR_LSB;
   assign addr_err = (lat_addr[ADDR_LSB-1:0] != '0) || (word_idx >= N'(DEPTH));

   // RAM is touched only in ACCESS for a legal address; reset blocks the write
   assign ram_en = (state == ST_ACCESS) && !addr_err;
   assign ram_be = (ram_en && lat_we && reset_n) ? lat_be : '0;

   sp_ram_bank #(
      .N     (N),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .be    (ram_be),
      .addr  (lat_addr[ADDR_LSB +: AW]),
      .wdata (lat_wdata),
      .rdata (ram_rdata)
   );

   // The RAM read register holds the word until the next access, which cannot
   // happen before the handshake, so gating it with rd_ok keeps rdata stable.
   assign o_resp_rdata = rd_ok ? ram_rdata : '0;
   assign o_req_ready  = ready_q;
   assign o_resp_valid = valid_q;
   assign o_resp_err   = err_q;

   // Request/response FSM with latency counter and registered response flags
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         rd_ok   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_req_valid && ready_q) begin
                  lat_we    <= i_req_we;
                  lat_addr  <= i_req_addr;
                  lat_wdata <= i_req_wdata;
                  lat_be    <= i_req_be;
                  ready_q   <= 1'b0;
                  cnt       <= '0;
                  state     <= (LATENCY > 0) ? ST_WAIT : ST_ACCESS;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (cnt == 4'(LATENCY - 1)) begin
                  cnt   <= '0;
                  state <= ST_ACCESS;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            ST_ACCESS: begin
               err_q   <= addr_err;
               rd_ok   <= !addr_err && !lat_we;
               valid_q <= 1'b1;
               state   <= ST_RESP;
            end
            ST_RESP: begin
               if (i_resp_ready) begin
                  valid_q <= 1'b0;
                  err_q   <= 1'b0;
                  rd_ok   <= 1'b0;
                  ready_q <= 1'b1;
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
